// File: rtl/vcu_msg_rx_endpoint_if.sv
// Link and CPU register bundle for the message receive endpoint.
// The master side is the sender plus the CPU; the slave side is the endpoint.
interface vcu_msg_rx_endpoint_if;
    logic [31:0] link_data_i;
    logic        link_valid_i;
    logic        credit_return_o;
    logic [31:0] vcu_reg_control;
    logic        vcu_reg_control_we;
    logic [31:0] vcu_reg_wdata;
    logic        vcu_reg_wdata_we;
    logic [31:0] vcu_reg_rdata;

    modport master (
        output link_data_i, link_valid_i,
        output vcu_reg_control, vcu_reg_control_we, vcu_reg_wdata, vcu_reg_wdata_we,
        input  credit_return_o, vcu_reg_rdata
    );

    modport slave (
        input  link_data_i, link_valid_i,
        input  vcu_reg_control, vcu_reg_control_we, vcu_reg_wdata, vcu_reg_wdata_we,
        output credit_return_o, vcu_reg_rdata
    );
endinterface

// File: rtl/vcu_msg_rx_endpoint.sv
// Receive endpoint of the credit-flow-controlled message link: buffers pushed
// words in a FWFT FIFO, exposes them to the CPU and returns a credit per pop.
module vcu_msg_rx_endpoint #(
    parameter  int DEPTH = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset_p,
    vcu_msg_rx_endpoint_if.slave          bus,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [LW-1:0]                 level,
    output logic                          err_o
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          credit_q, credit_d;

    logic [3:0]    func_s;
    logic          empty_s, full_s;
    logic          pop_req_s, pop_acc_s, push_acc_s;
    logic          ovf_set_s, udf_set_s, clr_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    assign func_s   = bus.vcu_reg_control[3:0];
    assign empty_s  = (level_q == LW'(0));
    assign full_s   = (level_q == LW'(DEPTH));
    assign unused_s = ^{bus.vcu_reg_control[31:4], bus.vcu_reg_wdata[31:2]};

    // Handshake decode and next-state computation for pointers, level and sticky errors.
    always_comb begin
        pop_req_s  = bus.vcu_reg_control_we && (func_s == 4'd5);
        pop_acc_s  = pop_req_s && !empty_s;
        // A pop in the same cycle frees the slot, so a push at full is still accepted.
        push_acc_s = bus.link_valid_i && (!full_s || pop_acc_s);
        ovf_set_s  = bus.link_valid_i && full_s && !pop_acc_s;
        udf_set_s  = pop_req_s && empty_s;
        clr_s      = bus.vcu_reg_wdata_we && (func_s == 4'd7);

        if (push_acc_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_acc_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        level_d  = level_q + LW'(push_acc_s) - LW'(pop_acc_s);
        ovf_d    = ovf_set_s | (ovf_q & ~(clr_s & bus.vcu_reg_wdata[0]));
        udf_d    = udf_set_s | (udf_q & ~(clr_s & bus.vcu_reg_wdata[1]));
        credit_d = pop_acc_s;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            level_q  <= LW'(0);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            credit_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            credit_q <= credit_d;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_q[wr_ptr_q] <= bus.link_data_i;
        end
    end

    // CPU read mux.
    always_comb begin
        rdata_s = 32'd0;
        case (func_s)
            4'd3:    rdata_s = {31'd0, ~empty_s};
            4'd6:    rdata_s = {{(32-LW){1'b0}}, level_q};
            4'd7:    rdata_s = {30'd0, udf_q, ovf_q};
            4'd9: begin
                if (empty_s) begin
                    rdata_s = 32'd0;
                end else begin
                    rdata_s = mem_q[rd_ptr_q];
                end
            end
            default: rdata_s = 32'd0;
        endcase
    end

    assign bus.vcu_reg_rdata   = rdata_s;
    assign bus.credit_return_o = credit_q;
    assign fifo_empty          = empty_s;
    assign fifo_full           = full_s;
    assign level               = level_q;
    assign err_o               = ovf_q | udf_q;
endmodule

// File: tb/tb_vcu_msg_rx_endpoint.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor compares them.
module tb_vcu_msg_rx_endpoint;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    localparam int K_REG    = 0;
    localparam int K_LEVEL  = 1;
    localparam int K_EMPTY  = 2;
    localparam int K_FULL   = 3;
    localparam int K_ERR    = 4;
    localparam int K_CREDIT = 5;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic          clk = 1'b0;
    logic          reset_p;
    logic          fifo_empty, fifo_full, err_o;
    logic [LW-1:0] level;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    chk_t chk_q[$];
    int   cred_q[$];

    vcu_msg_rx_endpoint_if bus();

    vcu_msg_rx_endpoint #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .bus       (bus),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .level     (level),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: drain queued expectations and track credit pulses.
    always @(negedge clk) begin : mon
        chk_t        c;
        logic [31:0] act;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.kind)
                K_REG:    act = bus.vcu_reg_rdata;
                K_LEVEL:  act = 32'(level);
                K_EMPTY:  act = {31'd0, fifo_empty};
                K_FULL:   act = {31'd0, fifo_full};
                K_ERR:    act = {31'd0, err_o};
                default:  act = {31'd0, bus.credit_return_o};
            endcase
            vectors++;
            if (act !== c.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, act, c.exp, cyc);
            end
        end
        if (bus.credit_return_o === 1'b1) begin
            vectors++;
            if (cred_q.size() > 0 && cred_q[0] == cyc) begin
                void'(cred_q.pop_front());
            end else begin
                miscompares++;
                $display("FAIL credit_unexpected: got pulse at cycle %0d expected none", cyc);
            end
        end
        if (cred_q.size() > 0 && cred_q[0] < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL credit_missing: got no pulse expected one at cycle %0d", cred_q[0]);
            void'(cred_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        chk_q.push_back(c);
    endtask

    // Select a register, queue its expectation and let the monitor sample it.
    task automatic check_reg(input logic [3:0] code, input logic [31:0] exp, input string name);
        bus.vcu_reg_control = {28'd0, code};
        expect_val(K_REG, exp, name);
        @(negedge clk);
        #1;
    endtask

    task automatic check_sig(input int kind, input logic [31:0] exp, input string name);
        expect_val(kind, exp, name);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        tick();
        reset_p = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        bus.link_data_i  = w;
        bus.link_valid_i = 1'b1;
        tick();
        bus.link_valid_i = 1'b0;
    endtask

    task automatic pop(input bit credit_expected);
        bus.vcu_reg_control    = 32'd5;
        bus.vcu_reg_control_we = 1'b1;
        if (credit_expected) cred_q.push_back(cyc + 1);
        tick();
        bus.vcu_reg_control_we = 1'b0;
        bus.vcu_reg_control    = 32'd0;
    endtask

    task automatic push_pop(input logic [31:0] w);
        bus.link_data_i        = w;
        bus.link_valid_i       = 1'b1;
        bus.vcu_reg_control    = 32'd5;
        bus.vcu_reg_control_we = 1'b1;
        cred_q.push_back(cyc + 1);
        tick();
        bus.link_valid_i       = 1'b0;
        bus.vcu_reg_control_we = 1'b0;
        bus.vcu_reg_control    = 32'd0;
    endtask

    task automatic w1c(input logic [31:0] mask);
        bus.vcu_reg_control  = 32'd7;
        bus.vcu_reg_wdata    = mask;
        bus.vcu_reg_wdata_we = 1'b1;
        tick();
        bus.vcu_reg_wdata_we = 1'b0;
        bus.vcu_reg_control  = 32'd0;
    endtask

    initial begin
        reset_p                = 1'b1;
        bus.link_data_i        = 32'd0;
        bus.link_valid_i       = 1'b0;
        bus.vcu_reg_control    = 32'd0;
        bus.vcu_reg_control_we = 1'b0;
        bus.vcu_reg_wdata      = 32'd0;
        bus.vcu_reg_wdata_we   = 1'b0;
        tick();
        do_reset();

        // Reset state
        check_sig(K_LEVEL, 32'd0, "rst_level");
        check_sig(K_EMPTY, 32'd1, "rst_empty");
        check_sig(K_FULL, 32'd0, "rst_full");
        check_sig(K_ERR, 32'd0, "rst_err");
        check_sig(K_CREDIT, 32'd0, "rst_credit");
        check_reg(4'd9, 32'd0, "rst_reg9");

        // Three pushes, FWFT head
        push(32'h11);
        check_reg(4'd9, 32'h11, "fwft_after_1_push");
        push(32'h22);
        push(32'h33);
        check_sig(K_LEVEL, 32'd3, "level_3");
        check_reg(4'd3, 32'd1, "reg3_nonempty");
        check_reg(4'd9, 32'h11, "reg9_head_11");
        check_reg(4'd6, 32'd3, "reg6_level_3");

        // Single pop exposes the next head, then two back-to-back pops
        pop(1'b1);
        check_reg(4'd9, 32'h22, "reg9_head_22");
        pop(1'b1);
        pop(1'b1);
        check_reg(4'd9, 32'd0, "reg9_empty");
        check_sig(K_EMPTY, 32'd1, "empty_after_pops");
        check_reg(4'd3, 32'd0, "reg3_empty");

        // Fill to full, overflow, clear
        for (int i = 0; i < DEPTH; i++) push(32'(i));
        check_sig(K_FULL, 32'd1, "full_after_8");
        push(32'hAA);
        check_reg(4'd7, 32'd1, "reg7_overflow");
        check_sig(K_ERR, 32'd1, "err_overflow");
        check_sig(K_LEVEL, 32'd8, "level_after_drop");
        w1c(32'd1);
        check_reg(4'd7, 32'd0, "reg7_cleared");
        check_sig(K_ERR, 32'd0, "err_cleared");

        // Push+pop at full, then drain across the wrap
        push_pop(32'hBB);
        check_sig(K_LEVEL, 32'd8, "level_pushpop_full");
        check_reg(4'd7, 32'd0, "no_ovf_pushpop");
        for (int i = 1; i < DEPTH; i++) begin
            check_reg(4'd9, 32'(i), "drain_head");
            pop(1'b1);
        end
        check_reg(4'd9, 32'hBB, "drain_head_bb");
        pop(1'b1);
        check_sig(K_EMPTY, 32'd1, "empty_after_drain");

        // Underflow and clear
        pop(1'b0);
        check_reg(4'd7, 32'd2, "reg7_underflow");
        check_sig(K_ERR, 32'd1, "err_underflow");
        check_sig(K_LEVEL, 32'd0, "level_after_udf");
        w1c(32'd2);
        check_reg(4'd7, 32'd0, "reg7_udf_cleared");

        // Overflow set wins over same-cycle clear
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
        bus.link_data_i      = 32'hCC;
        bus.link_valid_i     = 1'b1;
        bus.vcu_reg_control  = 32'd7;
        bus.vcu_reg_wdata    = 32'd1;
        bus.vcu_reg_wdata_we = 1'b1;
        tick();
        bus.link_valid_i     = 1'b0;
        bus.vcu_reg_wdata_we = 1'b0;
        check_reg(4'd7, 32'd1, "set_wins_over_clear");
        check_reg(4'd9, 32'h100, "head_after_drop");

        // Reset mid-stream discards words, credits and errors
        do_reset();
        check_sig(K_LEVEL, 32'd0, "reset_clears_full");
        pop(1'b0);
        for (int i = 0; i < 5; i++) push(32'h51 + 32'(i));
        check_sig(K_LEVEL, 32'd5, "level_5");
        check_sig(K_ERR, 32'd1, "err_before_reset");
        do_reset();
        check_sig(K_LEVEL, 32'd0, "mid_reset_level");
        check_reg(4'd9, 32'd0, "mid_reset_reg9");
        check_sig(K_CREDIT, 32'd0, "mid_reset_credit");
        check_sig(K_ERR, 32'd0, "mid_reset_err");
        check_sig(K_EMPTY, 32'd1, "mid_reset_empty");
        push(32'h77);
        check_reg(4'd9, 32'h77, "head_after_reset");
        check_sig(K_LEVEL, 32'd1, "level_after_reset_push");

        tick();
        tick();
        vectors++;
        if (cred_q.size() != 0) begin
            miscompares++;
            $display("FAIL credit_outstanding: got %0d pending expected 0", cred_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vcu_msg_rx_endpoint.md
Name: vcu_msg_rx_endpoint

Overview:
- Receiving end of the credit-flow-controlled message link between two sr_cpu_vc cores.
- Accepts 32-bit words pushed by the sender and buffers them in a DEPTH-entry FIFO.
- Exposes the buffered words to the receiving CPU through its vcu register interface.
- Returns one credit to the sender for every word the CPU pops; the sender's credit counter starts at DEPTH after reset.

Parameters:
- DEPTH, 8, FIFO entries and initial sender credit; power of 2, 2..64.
- LW, $clog2(DEPTH)+1, width of the level count (derived, not overridden).

Ports:
- clk  in  1  clock
- reset_p  in  1  synchronous, active-high reset
- link_data_i  in  32  message word from sender
- link_valid_i  in  1  1 = push link_data_i this cycle
- credit_return_o  out  1  one-cycle pulse = one entry freed
- vcu_reg_control  in  32  CPU control register; [3:0] selects function
- vcu_reg_control_we  in  1  1 = new value in vcu_reg_control
- vcu_reg_wdata  in  32  CPU write data
- vcu_reg_wdata_we  in  1  1 = CPU write strobe
- vcu_reg_rdata  out  32  CPU read data, combinational
- fifo_empty  out  1  level == 0
- fifo_full  out  1  level == DEPTH
- level  out  LW  entries currently held
- err_o  out  1  OR of sticky error bits

Behaviour:
- Reset (reset_p sampled high at a clk edge):
  - Pointers, level, credit_return_o and sticky bits all go to 0.
  - FIFO contents are don't-care.
  - Reset mid-operation discards all stored words; no credits are returned for discarded words.
- Pop:
  - Condition: control[3:0]==5 and vcu_reg_control_we==1.
  - Pop with fifo_empty=1 is ignored: no credit is returned, and sticky underflow (bit1) is set.
- Push:
  - Condition: link_valid_i==1.
  - Accepted if fifo_full==0, or if a valid pop occurs in the same cycle.
  - Push at full with no pop: word dropped, level unchanged, sticky overflow (bit0) set.
- Simultaneous push and pop: level unchanged; pointers both advance.
- Level update: level += push_acc - pop_acc.
- Pointers: log2(DEPTH)-bit, wrap naturally from DEPTH-1 to 0.
- Read path (first-word-fall-through):
  - Head word is visible at register 9 with no latency.
  - A word pushed at edge N is readable after edge N.
- credit_return_o:
  - Registered: high for exactly the cycle after each accepted pop.
  - Back-to-back pops give back-to-back pulses.
  - Never high in the cycle after reset.
- vcu_reg_rdata, decoded from control[3:0]:
  - 3: {31'b0, ~fifo_empty}
  - 9: head word, or 0 when empty
  - 6: level zero-extended to 32
  - 7: {30'b0, underflow, overflow}
  - all other codes: 0
- Error clear:
  - control[3:0]==7 with vcu_reg_wdata_we==1 is write-1-to-clear on sticky bits using wdata[1:0].
  - A set event in the same cycle wins over the clear.
- err_o = overflow | underflow.
- No combinational path from link inputs to credit_return_o.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> level=3; reg3 reads 1; reg9 reads 0x11; credit_return_o stays 0.
- Pop three times on consecutive cycles (control=5 with control_we) -> reg9 reads 0x22, then 0x33, then 0; credit_return_o high for 3 consecutive cycles, each one cycle after its pop; fifo_empty=1 afterwards.
- Push DEPTH=8 words 0..7 -> fifo_full=1. Then push 0xAA alone -> dropped; reg7 reads 1; err_o=1; level stays 8. Then write control=7, wdata=1, wdata_we -> reg7 reads 0.
- With fifo_full=1, push 0xBB and pop in the same cycle -> level stays 8; no overflow; one credit pulse; after draining 7 more words, the last word popped is 0xBB (wrap-around verified).
- Pop while empty -> reg7 bit1=1; no credit pulse. Then set underflow and write W1C in the same cycle -> bit stays 1.
- Push 5 words, assert reset_p for 1 cycle mid-stream -> level=0, reg9 reads 0, credit_return_o=0, err_o=0; the next push is readable as the head word.
